seg_display_capture: RTL
========================

Name: seg_display_capture

Overview:
- Receive side of the multiplexed 7-segment interface.
- Samples the shared segment lines (a..g, dp) and the active-low digit anodes (AN0..AN2) as produced by the display multiplexer.
- Rebuilds the per-digit segment patterns, decodes each into a hex nibble, and flags stale digits and bus conflicts.
- Used as a board-level loopback checker and as a display-to-register bridge for self-test of the CPU's output path.

Parameters:
- SEG_ACTIVE_LOW, 1, 1 = a lit segment is driven 0; input is normalised to active-high internally.
- STABLE_CYCLES, 4, synchronised bus must hold unchanged this many clk cycles before capture (range 1..255).
- TIMEOUT_CYCLES, 65536, clk cycles without a refresh before a digit's valid drops (range 2..2^24).

Ports:
- clk  input  1  sampling clock; must be at least 4x faster than the multiplexer clock.
- rst_n  input  1  asynchronous active-low reset.
- a, b, c, d, e, f, g, dp  input  1 each  shared segment lines, asynchronous to clk.
- AN0, AN1, AN2  input  1 each  digit anodes, active-low, asynchronous to clk.
- clr_err  input  1  synchronous clear of err_multi.
- digit0_seg, digit1_seg, digit2_seg  output  8 each  captured pattern {dp,g,f,e,d,c,b,a}, active-high.
- digit0_hex, digit1_hex, digit2_hex  output  4 each  decoded nibble.
- digit_hex_ok  output  3  bit n = digitn_seg[6:0] matches a hex glyph.
- digit_valid  output  3  bit n = digit n refreshed within TIMEOUT_CYCLES.
- update  output  1  one-cycle pulse on every capture.
- update_idx  output  2  digit index of the last capture; held between captures.
- err_multi  output  1  sticky: two or more anodes seen low in one stable window.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; sync flops and stability counter 0; capture-done flag 0; timeout counters 0.
- Input synchroniser:
  - Two-flop synchroniser on all 11 inputs; segment polarity is normalised after the second flop.
  - Call the result bus_s (11 bits).
- Stability counter:
  - When bus_s differs from its previous-cycle value: counter <= 0 and capture-done <= 0.
  - Otherwise the counter increments and saturates at STABLE_CYCLES.
- Capture condition: the counter reaches STABLE_CYCLES and capture-done = 0. The capture fires once per stable window.
  - Exactly one anode low: write the 8-bit segment value into that digit's register, set update_idx, pulse update, reset that digit's timeout counter, set capture-done.
  - All anodes high: set capture-done; no write, no pulse (blanking interval).
  - Two or more anodes low: set err_multi and capture-done; no write, no pulse.
- Latency: an input change that is stable from edge t becomes visible in the digit register and on update at edge t+2+STABLE_CYCLES.
- Decode (combinational from the digit register):
  - Lookup on seg[6:0]: 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F.
  - No match: hex=0 and hex_ok=0.
  - dp is ignored for decode.
- Timeout:
  - Each digit has a counter that saturates at TIMEOUT_CYCLES-1.
  - digit_valid[n] = 1 after a capture to digit n; it drops to 0 when the counter saturates.
  - Valid returns to 1 on the next capture to that digit.
- err_multi:
  - Cleared only by reset or clr_err.
  - If clr_err and a new conflict occur in the same cycle, set wins.
- Digit 2: AN2 is tied high by the current two-digit driver. Digit 2 therefore stays invalid unless AN2 is driven low.
- Glitch of 1 clk: it resets the stability counter. No capture occurs for the glitch value; the window restarts.
- Reset mid-window discards any partially counted window.

Decomposition:
- Shared package seg7_pkg:
  - Glyph constants SEG_HEX_0..SEG_HEX_F (8-bit, active-high, {dp,g,f,e,d,c,b,a}).
  - Bit-index constants SEG_A..SEG_DP.
  - NUM_DIGITS=3.
- The same package serves the existing hex-to-segment encoders.
- One natural sub-module: seg7_hex_decode (8-bit pattern in, 4-bit nibble + ok out, purely combinational), instantiated once per digit.

Test Plan:
- Reset, then drive AN0=0, AN1=1, AN2=1 with segments for "5" (active-low 0x92), held 10 cycles -> update pulses once at cycle 6; digit0_seg=0x6D, digit0_hex=5, digit_hex_ok[0]=1, digit_valid=3'b001.
- Alternate AN0/AN1 every 8 cycles with "3" / "A" -> digit0_hex=3, digit1_hex=A; update_idx alternates 0,1; exactly one update per phase.
- 1-cycle glitch on segment b during a stable AN1 window -> no capture of the glitch value; digit1_seg holds its previous value; one update after the bus re-stabilises.
- AN0=AN1=0 held 6 cycles -> err_multi=1, no update; assert clr_err -> err_multi=0 next cycle; assert clr_err together with a new conflict -> err_multi stays 1.
- TIMEOUT_CYCLES=16: capture digit0, then hold all anodes high 20 cycles -> digit_valid[0] drops at cycle 16 after the capture; next capture restores it.
- Pattern 0x49 (no glyph) captured on digit1 -> digit1_hex=0, digit_hex_ok[1]=0; assert rst_n low mid-window -> all outputs 0 immediately.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit positions, hex glyphs in
// {dp,g,f,e,d,c,b,a} active-high form, and the digit count of the display.
// The same glyph table serves the hex-to-segment encoders and the capture decoder.
package seg7_pkg;

  localparam int NUM_DIGITS = 3;

  // Bit positions inside an 8-bit segment pattern
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Hex glyphs, dp off
  localparam logic [7:0] SEG_HEX_0 = 8'h3F;
  localparam logic [7:0] SEG_HEX_1 = 8'h06;
  localparam logic [7:0] SEG_HEX_2 = 8'h5B;
  localparam logic [7:0] SEG_HEX_3 = 8'h4F;
  localparam logic [7:0] SEG_HEX_4 = 8'h66;
  localparam logic [7:0] SEG_HEX_5 = 8'h6D;
  localparam logic [7:0] SEG_HEX_6 = 8'h7D;
  localparam logic [7:0] SEG_HEX_7 = 8'h07;
  localparam logic [7:0] SEG_HEX_8 = 8'h7F;
  localparam logic [7:0] SEG_HEX_9 = 8'h6F;
  localparam logic [7:0] SEG_HEX_A = 8'h77;
  localparam logic [7:0] SEG_HEX_B = 8'h7C;
  localparam logic [7:0] SEG_HEX_C = 8'h39;
  localparam logic [7:0] SEG_HEX_D = 8'h5E;
  localparam logic [7:0] SEG_HEX_E = 8'h79;
  localparam logic [7:0] SEG_HEX_F = 8'h71;

  // Nibble to glyph, used by the display-side encoders
  function automatic logic [7:0] seg7_encode(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0: pat = SEG_HEX_0;
      4'h1: pat = SEG_HEX_1;
      4'h2: pat = SEG_HEX_2;
      4'h3: pat = SEG_HEX_3;
      4'h4: pat = SEG_HEX_4;
      4'h5: pat = SEG_HEX_5;
      4'h6: pat = SEG_HEX_6;
      4'h7: pat = SEG_HEX_7;
      4'h8: pat = SEG_HEX_8;
      4'h9: pat = SEG_HEX_9;
      4'hA: pat = SEG_HEX_A;
      4'hB: pat = SEG_HEX_B;
      4'hC: pat = SEG_HEX_C;
      4'hD: pat = SEG_HEX_D;
      4'hE: pat = SEG_HEX_E;
      default: pat = SEG_HEX_F;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational glyph-to-nibble decoder. The decimal point is ignored; an
// unrecognised pattern decodes to 0 with ok low.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [7:0] seg,
  output logic [3:0] hex,
  output logic       ok
);

  // Match the seven glyph segments against the hex table
  always_comb begin
    hex = 4'h0;
    ok  = 1'b1;
    case (seg[6:0])
      SEG_HEX_0[6:0]: hex = 4'h0;
      SEG_HEX_1[6:0]: hex = 4'h1;
      SEG_HEX_2[6:0]: hex = 4'h2;
      SEG_HEX_3[6:0]: hex = 4'h3;
      SEG_HEX_4[6:0]: hex = 4'h4;
      SEG_HEX_5[6:0]: hex = 4'h5;
      SEG_HEX_6[6:0]: hex = 4'h6;
      SEG_HEX_7[6:0]: hex = 4'h7;
      SEG_HEX_8[6:0]: hex = 4'h8;
      SEG_HEX_9[6:0]: hex = 4'h9;
      SEG_HEX_A[6:0]: hex = 4'hA;
      SEG_HEX_B[6:0]: hex = 4'hB;
      SEG_HEX_C[6:0]: hex = 4'hC;
      SEG_HEX_D[6:0]: hex = 4'hD;
      SEG_HEX_E[6:0]: hex = 4'hE;
      SEG_HEX_F[6:0]: hex = 4'hF;
      default: begin
        hex = 4'h0;
        ok  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg_display_capture.sv
// Receive side of a multiplexed 7-segment bus. Synchronises the shared
// segment lines and digit anodes, waits for the bus to settle, then latches
// the pattern into the digit whose anode is low. Each captured digit is
// decoded to hex and tracked for staleness; overlapping anodes raise a
// sticky error.
module seg_display_capture
  import seg7_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       dp,
  input  logic       AN0,
  input  logic       AN1,
  input  logic       AN2,
  input  logic       clr_err,
  output logic [7:0] digit0_seg,
  output logic [7:0] digit1_seg,
  output logic [7:0] digit2_seg,
  output logic [3:0] digit0_hex,
  output logic [3:0] digit1_hex,
  output logic [3:0] digit2_hex,
  output logic [2:0] digit_hex_ok,
  output logic [2:0] digit_valid,
  output logic       update,
  output logic [1:0] update_idx,
  output logic       err_multi
);

  localparam int              TO_W       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_MAX     = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0]      SEG_POL    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  // Bus layout: [10:3] segments {dp,g,f,e,d,c,b,a}, [2:0] anodes {AN2,AN1,AN0}
  logic [10:0] bus_raw;
  logic [10:0] sync1;
  logic [10:0] sync2;
  logic [10:0] bus_s;
  logic [10:0] bus_prev;
  logic [1:0]  fill;
  logic [7:0]  stable_cnt;
  logic        cap_done;

  logic        bus_same;
  logic        cap_fire;
  logic [2:0]  an_low;
  logic        cap_one;
  logic        cap_multi;
  logic [1:0]  cap_idx;
  logic        cap_write;
  logic        cap_conflict;

  logic [7:0]  digit_reg [NUM_DIGITS];
  logic [3:0]  hex_arr   [NUM_DIGITS];

  assign bus_raw = {dp, g, f, e, d, c, b, a, AN2, AN1, AN0};
  // Segments normalised to active-high after the second flop
  assign bus_s   = {sync2[10:3] ^ SEG_POL, sync2[2:0]};

  // Two-flop synchroniser, previous-cycle copy, and a fill counter that
  // keeps the reset contents of the synchroniser from forming a window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      bus_prev <= '0;
      fill     <= '0;
    end else begin
      sync1    <= bus_raw;
      sync2    <= sync1;
      bus_prev <= bus_s;
      if (fill != 2'd2) fill <= fill + 2'd1;
    end
  end

  assign bus_same = (bus_s == bus_prev);
  // Fires on the cycle the counter would step onto STABLE_CYCLES
  assign cap_fire = (fill == 2'd2) && bus_same && !cap_done &&
                    (stable_cnt == STABLE_MAX - 8'd1);
  assign an_low   = ~bus_s[2:0];

  // Classify the anode pattern of the settled window
  always_comb begin
    cap_one = 1'b1;
    cap_idx = 2'd0;
    case (an_low)
      3'b001:  cap_idx = 2'd0;
      3'b010:  cap_idx = 2'd1;
      3'b100:  cap_idx = 2'd2;
      default: cap_one = 1'b0;
    endcase
    cap_multi = (an_low & (an_low - 3'd1)) != 3'd0;
  end

  assign cap_write    = cap_fire & cap_one;
  assign cap_conflict = cap_fire & cap_multi;

  // Stability counter; any bus change restarts the window and re-arms capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
      cap_done   <= 1'b0;
    end else if (fill != 2'd2 || !bus_same) begin
      stable_cnt <= '0;
      cap_done   <= 1'b0;
    end else begin
      if (stable_cnt != STABLE_MAX) stable_cnt <= stable_cnt + 8'd1;
      if (cap_fire) cap_done <= 1'b1;
    end
  end

  // Digit registers and the capture strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_reg[i] <= '0;
      update     <= 1'b0;
      update_idx <= '0;
    end else begin
      update <= cap_write;
      if (cap_write) begin
        digit_reg[cap_idx] <= bus_s[10:3];
        update_idx         <= cap_idx;
      end
    end
  end

  // Sticky anode-overlap flag; a new conflict beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_multi <= 1'b0;
    end else if (cap_conflict) begin
      err_multi <= 1'b1;
    end else if (clr_err) begin
      err_multi <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [TO_W-1:0] to_cnt;
    logic            vld;

    // Per-digit staleness timer; valid drops once the timer saturates
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        to_cnt <= '0;
        vld    <= 1'b0;
      end else if (cap_write && (cap_idx == 2'(i))) begin
        to_cnt <= '0;
        vld    <= 1'b1;
      end else begin
        if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
        else                  vld    <= 1'b0;
      end
    end

    assign digit_valid[i] = vld;

    seg7_hex_decode u_dec (
      .seg (digit_reg[i]),
      .hex (hex_arr[i]),
      .ok  (digit_hex_ok[i])
    );
  end

  assign digit0_seg = digit_reg[0];
  assign digit1_seg = digit_reg[1];
  assign digit2_seg = digit_reg[2];
  assign digit0_hex = hex_arr[0];
  assign digit1_hex = hex_arr[1];
  assign digit2_hex = hex_arr[2];

endmodule
